// File: rtl/adc_trig_pkg.sv
// adc_trig_pkg: state encoding and shared widths for the ADC trigger controller
package adc_trig_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    ARMED   = 2'd2,
    CAPTURE = 2'd3
  } state_e;
  localparam int TS_WIDTH = 32;
endpackage

// File: rtl/adc_trig_ring.sv
// adc_trig_ring: simple dual-port pre-trigger ring RAM with one-cycle registered read
module adc_trig_ring
  import adc_trig_pkg::*;
#(
  parameter int DW = 15,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  // write port and enabled read register; rdata holds while re is low
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/adc_trigger_ctrl.sv
// adc_trigger_ctrl: arm/fill/trigger/capture sequencer for the ADC sum stream (ADC_TRIG_TIMESTAMP_EN adds trig_timestamp)
module adc_trigger_ctrl
  import adc_trig_pkg::*;
#(
  parameter int DATA_WIDTH = 15,
  parameter int RING_DEPTH = 1024,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(RING_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  input  logic [31:0]          s_axis_tdata,
  input  logic [15:0]          trigger_level,
  input  logic [AW-1:0]        pre_samples,
  input  logic [CNT_WIDTH-1:0] post_samples,
  input  logic                 arm,
  input  logic                 abort,
  output logic                 m_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic                 overrun
`ifdef ADC_TRIG_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]  trig_timestamp
`endif
);
  localparam int PW = AW + 1;
  localparam int RW = CNT_WIDTH + 1;
  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, fill_q, fill_nxt;
  logic [AW-1:0]         pre_q;
  logic [CNT_WIDTH-1:0]  post_q, post_eff, wrem_q;
  logic [RW-1:0]         rem_q;
  logic [DATA_WIDTH-1:0] prev_q, od_q, sample, ram_rdata;
  logic                  rv_q, rl_q, ov_q, ol_q, ovr_q;
  logic [AW+1:0]         occ;
  logic                  xfer, cap_wr, ovf, trig, we, load, re, done, arm_ok;
  logic                  unused_tdata;
  assign unused_tdata = ^s_axis_tdata[31:DATA_WIDTH];
  assign sample   = s_axis_tdata[DATA_WIDTH-1:0];
  assign post_eff = post_q == '0 ? CNT_WIDTH'(1) : post_q;
  // occupancy counts unread ring entries plus beats sitting in the read and output stages
  assign occ      = {1'b0, wr_ptr_q - rd_ptr_q} + (AW+2)'(rv_q) + (AW+2)'(ov_q);
  assign xfer     = ov_q && m_axis_tready;
  assign done     = xfer && ol_q;
  assign cap_wr   = state_q == CAPTURE && s_axis_tvalid && wrem_q != '0;
  assign ovf      = cap_wr && occ == (AW+2)'(RING_DEPTH);
  assign trig     = state_q == ARMED && s_axis_tvalid &&
                    32'(prev_q) <= 32'(trigger_level) && 32'(sample) > 32'(trigger_level);
  assign we       = s_axis_tvalid && (state_q == FILL || state_q == ARMED || (cap_wr && !ovf));
  assign fill_nxt = fill_q + PW'(we);
  assign load     = rv_q && (!ov_q || xfer);
  assign re       = state_q == CAPTURE && rem_q != '0 && wr_ptr_q != rd_ptr_q && (!rv_q || load);
  assign arm_ok   = state_q == IDLE && arm && !abort;
  adc_trig_ring #(.DW(DATA_WIDTH), .DEPTH(RING_DEPTH)) u_ring (
    .clk_i  (aclk),
    .we_i   (we),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(sample),
    .re_i   (re),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(ram_rdata)
  );
  // state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state; abort wins over arm and trigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arm ? FILL : IDLE;
      FILL:    state_d = fill_nxt >= {1'b0, pre_q} ? ARMED : FILL;
      ARMED:   state_d = trig ? CAPTURE : ARMED;
      default: state_d = ovf || done ? IDLE : CAPTURE;
    endcase
    if (abort) state_d = IDLE;
  end
  // pointers, counters, crossing history and the read/output pipeline
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pre_q    <= '0;
      post_q   <= '0;
      wrem_q   <= '0;
      rem_q    <= '0;
      prev_q   <= '0;
      od_q     <= '0;
      rv_q     <= 1'b0;
      rl_q     <= 1'b0;
      ov_q     <= 1'b0;
      ol_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (we) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (state_q == FILL) fill_q <= fill_nxt;
      if (s_axis_tvalid) prev_q <= sample;
      if (re) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        rem_q    <= rem_q - RW'(1);
        rl_q     <= rem_q == RW'(1);
      end
      if (cap_wr && !ovf) wrem_q <= wrem_q - CNT_WIDTH'(1);
      if (trig) begin
        rd_ptr_q <= wr_ptr_q - PW'(pre_q);
        rem_q    <= RW'(pre_q) + RW'(post_eff);
        wrem_q   <= post_eff - CNT_WIDTH'(1);
      end
      rv_q <= re || (rv_q && !load);
      if (load) begin
        ov_q <= 1'b1;
        ol_q <= rl_q;
        od_q <= ram_rdata;
      end else if (xfer) ov_q <= 1'b0;
      if (ovf) ovr_q <= 1'b1;
      if (state_d == IDLE) begin
        rv_q <= 1'b0;
        ov_q <= 1'b0;
        ol_q <= 1'b0;
      end
      if (arm_ok) begin
        pre_q    <= pre_samples;
        post_q   <= post_samples;
        ovr_q    <= 1'b0;
        wr_ptr_q <= '0;
        fill_q   <= '0;
        prev_q   <= '0;
      end
    end
  end
`ifdef ADC_TRIG_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_q;
  // free-running valid-sample count, captured at the trigger sample
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      if (s_axis_tvalid) ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
      if (trig && !abort) ts_q <= ts_cnt_q;
    end
  end
  assign trig_timestamp = ts_q;
`endif
  assign m_axis_tvalid = ov_q;
  assign m_axis_tdata  = 32'(od_q);
  assign m_axis_tlast  = ov_q && ol_q;
  assign busy          = state_q != IDLE;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_adc_trigger_ctrl.sv
// tb_adc_trigger_ctrl: directed checks of the trigger controller with a 16-entry ring
module tb_adc_trigger_ctrl;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic [15:0] trigger_level;
  logic [3:0]  pre_samples;
  logic [15:0] post_samples;
  logic        arm, abort;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        busy, overrun;
`ifdef ADC_TRIG_TIMESTAMP_EN
  logic [31:0] trig_timestamp;
`endif
  int n_chk = 0;
  int n_bad = 0;
  int first, nb, seen, ovr_at;
  int exp3 [6] = '{150, 150, 150, 50, 150, 150};

  adc_trigger_ctrl #(.DATA_WIDTH(15), .RING_DEPTH(16), .CNT_WIDTH(16)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .trigger_level(trigger_level),
    .pre_samples  (pre_samples),
    .post_samples (post_samples),
    .arm          (arm),
    .abort        (abort),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .overrun      (overrun)
`ifdef ADC_TRIG_TIMESTAMP_EN
    ,
    .trig_timestamp(trig_timestamp)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic v, input int d);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_arm(input logic [3:0] pre, input logic [15:0] post, input logic [15:0] lvl);
    pre_samples   = pre;
    post_samples  = post;
    trigger_level = lvl;
    arm           = 1'b1;
    cycle(1'b0, 0);
    arm           = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    trigger_level = '0;
    pre_samples = '0;
    post_samples = '0;
    arm = 1'b0;
    abort = 1'b0;
    m_axis_tready = 1'b1;
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    aresetn = 1'b1;
    cycle(1'b0, 0);

    do_arm(4, 8, 100);
    check("t2_busy_arm", busy, 1);
    first = -1;
    nb = 0;
    for (int i = 0; i < 130; i++) begin
      cycle(1'b1, i);
      if (m_axis_tvalid) begin
        if (first < 0) first = i;
        check("t2_data", m_axis_tdata, 97 + nb);
        check("t2_last", m_axis_tlast, nb == 11);
        nb++;
      end
    end
    check("t2_count", nb, 12);
    check("t2_first", first, 103);
    check("t2_busy_end", busy, 0);

    do_arm(4, 2, 100);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 150);
      if (m_axis_tvalid) seen++;
    end
    check("t3_hold_valid", seen, 0);
    check("t3_hold_busy", busy, 1);
    cycle(1'b1, 50);
    first = -1;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 150);
      if (m_axis_tvalid) begin
        if (first < 0) first = i;
        check("t3_data", m_axis_tdata, nb < 6 ? exp3[nb] : -1);
        check("t3_last", m_axis_tlast, nb == 5);
        nb++;
      end
    end
    check("t3_count", nb, 6);
    check("t3_first", first, 2);
    check("t3_busy_end", busy, 0);

    do_arm(0, 1, 100);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    cycle(1'b1, 50);
    first = -1;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(i == 0, i == 0 ? 150 : 0);
      if (m_axis_tvalid) begin
        if (first < 0) first = i;
        check("t4_data", m_axis_tdata, 150);
        check("t4_last", m_axis_tlast, 1);
        nb++;
      end
    end
    check("t4_count", nb, 1);
    check("t4_first", first, 2);
    check("t4_busy_end", busy, 0);

    m_axis_tready = 1'b0;
    do_arm(2, 64, 100);
    ovr_at = -1;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      cycle(1'b1, i);
      if (m_axis_tlast) seen++;
      if (i == 114) begin
        check("t5_pre_overrun", overrun, 0);
        check("t5_pre_tvalid", m_axis_tvalid, 1);
        check("t5_stall_data", m_axis_tdata, 99);
        check("t5_pre_busy", busy, 1);
      end
      if (overrun && ovr_at < 0) begin
        ovr_at = i;
        check("t5_ovr_tvalid", m_axis_tvalid, 0);
        check("t5_ovr_busy", busy, 0);
      end
    end
    check("t5_ovr_cycle", ovr_at, 115);
    check("t5_no_tlast", seen, 0);
    check("t5_sticky", overrun, 1);

    do_arm(2, 64, 100);
    check("t5_arm_clears", overrun, 0);
    check("t6_busy_arm", busy, 1);
    for (int i = 0; i < 106; i++) cycle(1'b1, i);
    check("t6_in_capture", m_axis_tvalid, 1);
    abort = 1'b1;
    arm = 1'b1;
    cycle(1'b1, 106);
    abort = 1'b0;
    arm = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_tvalid", m_axis_tvalid, 0);
    cycle(1'b0, 0);
    check("t6_arm_ignored", busy, 0);

    do_arm(2, 64, 100);
    for (int i = 0; i < 106; i++) cycle(1'b1, i);
    check("t1_in_capture", m_axis_tvalid, 1);
    aresetn = 1'b0;
    cycle(1'b0, 0);
    check("t1_tvalid", m_axis_tvalid, 0);
    check("t1_tlast", m_axis_tlast, 0);
    check("t1_tdata", m_axis_tdata, 0);
    check("t1_busy", busy, 0);
    check("t1_overrun", overrun, 0);
    aresetn = 1'b1;
    cycle(1'b0, 0);
    check("t1_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
